lcd_ctrl: RTL
=============

# lcd_ctrl

Hardware HD44780 character-LCD controller sitting directly downstream of the core's LSU LCD register. It replaces software bit-banging of EN/RS/RW timing. The block runs the LCD power-up initialisation by itself, then accepts one command or data byte at a time over a valid/ready handshake. For each byte it generates the setup, enable-pulse, hold and execution-wait phases the panel requires.

## Interface
Parameters:
- CNT_W, 24: width of the shared phase counter.
- T_PWRUP, 750000: cycles waited after reset before the first init command.
- T_SETUP, 4: cycles RS/DATA are stable before EN rises.
- T_EN, 25: cycles EN is held high.
- T_HOLD, 4: cycles RS/DATA are held after EN falls.
- T_EXEC, 2500: execution wait for a normal command or data byte.
- T_CLEAR, 100000: execution wait for clear (0x01) and home (0x02/0x03) commands.

Ports (one clock; reset is synchronous and active-high):
- i_clk, in, 1: system clock, rising edge.
- i_rst, in, 1: synchronous active-high reset.
- i_lcd_on, in, 1: panel power request from the LCD register, bit 31.
- i_req_vld, in, 1: request valid.
- i_req_rs, in, 1: 0 = command, 1 = data.
- i_req_data, in, 8: byte to write.
- o_req_rdy, out, 1: controller can accept a request.
- o_init_done, out, 1: init sequence completed.
- o_lcd_on, out, 1: panel power.
- o_lcd_en, out, 1: LCD enable strobe.
- o_lcd_rs, out, 1: LCD register select.
- o_lcd_rw, out, 1: LCD read/write; tied 0, write only.
- o_lcd_data, out, 8: LCD data bus.

## Operation
- Reset values: o_req_rdy=0, o_init_done=0, o_lcd_on=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=8'h00, state=PWRUP.
- States and transitions:
  - PWRUP → INIT_LOAD after T_PWRUP cycles.
  - INIT_LOAD loads the next init-table entry (RS=0) → SETUP.
  - IDLE → SETUP on accept.
  - SETUP → PULSE → HOLD → EXEC.
  - EXEC → INIT_LOAD if init entries remain, else IDLE.
- Init table, in order: 0x38, 0x38, 0x0C, 0x01, 0x06 (8-bit, 2-line; display on; clear; entry mode increment).
- Accept rule: a request is accepted only in IDLE, when i_req_vld && o_req_rdy. RS and data are latched on that edge. i_req_* are ignored in every other state.
- o_req_rdy is 1 only in IDLE. It is registered, not combinational from i_req_vld.
- o_lcd_en is 1 only in PULSE. o_lcd_rs and o_lcd_data hold the latched byte from SETUP through the end of EXEC, and keep their last value in IDLE.
- EXEC duration is T_CLEAR when RS=0 and data ∈ {0x01, 0x02, 0x03}; otherwise it is T_EXEC. Init entries follow the same rule.
- o_init_done sets when the last init entry leaves EXEC. It stays 1 until reset.
- o_lcd_on is a registered copy of i_lcd_on. It has no effect on the FSM.
- Reset mid-operation: on the next edge EN drops to 0, all outputs take reset values, and the block restarts from PWRUP. A partially sent byte is discarded.

## Timing
- Every timed state lasts exactly its parameter in cycles. Each parameter must be ≥1 and <2^CNT_W.
- The counter loads (T−1) on state entry and the state exits the cycle after the counter reads 0.
- Accept edge → first SETUP cycle: 1 cycle. EN rises T_SETUP cycles after SETUP entry.
- Accept edge → o_req_rdy high again: T_SETUP + T_EN + T_HOLD + T_EXEC_or_CLEAR + 1 cycles.
- INIT_LOAD takes 1 cycle per entry.
- Back-to-back requests: i_req_vld may stay high. One byte is taken per IDLE visit, and there is at least 1 IDLE cycle between bytes.

## Structure
- Package lcd_pkg holds:
  - the state enum (PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, EXEC);
  - the init table as a localparam array plus INIT_LEN=5;
  - command constants CMD_CLEAR=8'h01 and CMD_HOME=8'h02.
- One sub-module, lcd_timer: a loadable CNT_W-bit down-counter with i_load, i_value and o_zero, shared by all timed states.

## Test plan
Bench parameters: T_PWRUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLEAR=10, CNT_W=8.

- Reset released, no requests → observe power-up and init:
  - o_lcd_en low for the first 20 cycles;
  - then exactly 5 EN pulses, each 3 cycles wide, carrying 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0;
  - o_init_done and o_req_rdy high at cycle 20 + 4·13 + 18 = 90.
- After init, data byte 0x41 with RS=1 → EN high on cycles 3–5 after accept, rs=1, data=0x41 stable from SETUP to EXEC end; rdy returns 13 cycles after accept.
- Command 0x01 with RS=0 after init → rdy returns 18 cycles after accept (T_CLEAR path).
- i_req_vld held high with 3 distinct bytes → exactly 3 EN pulses, in order, no byte dropped or duplicated, rdy low between them.
- i_req_vld asserted during PWRUP or init → ignored, no extra EN pulse; the request is accepted only after o_init_done.
- i_rst asserted during PULSE → EN 0 and all outputs at reset values on the next edge; the init sequence restarts from PWRUP.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the FSM state encoding, the power-up init table and the slow-command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_e;

    localparam int INIT_LEN = 5;

    // 8-bit 2-line, 8-bit 2-line, display on, clear, entry mode increment
    localparam logic [7:0] INIT_TABLE [INIT_LEN] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and both home encodings (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase of the LCD controller.
// Stops at zero; o_zero flags the last cycle of the current phase.
module lcd_timer #(
    parameter int                CNT_W     = 24,
    parameter logic [CNT_W-1:0]  RST_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= RST_VALUE;
        end else if (i_load) begin
            cnt_q <= i_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller: runs the power-up init table, then writes one byte per
// valid/ready handshake with setup, enable, hold and execution-wait phases.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 2500,
    parameter int T_CLEAR = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lcd_on,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    // Each phase loads T-1 so that it lasts exactly T cycles.
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR - 1);
    localparam logic [2:0]       INIT_END = 3'(INIT_LEN);

    lcd_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             rdy_q;
    logic             en_q;
    logic             lcd_on_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    lcd_timer #(
        .CNT_W     (CNT_W),
        .RST_VALUE (PWRUP_LD)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_zero  (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rs_d      = rs_q;
        data_d    = data_q;
        done_d    = done_q;
        tmr_load  = 1'b0;
        tmr_value = SETUP_LD;
        unique case (state_q)
            PWRUP: begin
                if (tmr_zero) state_d = INIT_LOAD;
            end
            INIT_LOAD: begin
                rs_d     = 1'b0;
                data_d   = INIT_TABLE[idx_q];
                idx_d    = idx_q + 3'd1;
                state_d  = SETUP;
                tmr_load = 1'b1;
            end
            IDLE: begin
                if (i_req_vld && rdy_q) begin
                    rs_d     = i_req_rs;
                    data_d   = i_req_data;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d   = PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = EN_LD;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d   = HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d   = EXEC;
                    tmr_load  = 1'b1;
                    tmr_value = is_long_cmd(rs_q, data_q) ? CLEAR_LD : EXEC_LD;
                end
            end
            EXEC: begin
                if (tmr_zero) begin
                    if (!done_q && (idx_q != INIT_END)) begin
                        state_d = INIT_LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    // Strobes are registered from the next state so they align with the state itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= PWRUP;
            idx_q    <= 3'd0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
            en_q     <= 1'b0;
            lcd_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            done_q   <= done_d;
            rdy_q    <= (state_d == IDLE);
            en_q     <= (state_d == PULSE);
            lcd_on_q <= i_lcd_on;
        end
    end

    assign o_req_rdy   = rdy_q;
    assign o_init_done = done_q;
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule
